// File: rtl/etapa_decodificacion_if.sv
// Bundle between the decode stage, its upstream fetch, the register file and execute.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface etapa_decodificacion_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // upstream instruction handshake
    logic              inst_valid;
    logic [31:0]       inst;
    logic              inst_ready;
    // writeback request from downstream
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    // banco_registros ports
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] dr1;
    logic [DATA_W-1:0] dr2;
    logic              reg_write;
    logic [ADDR_W-1:0] dir;
    logic [DATA_W-1:0] di;
    // execute stage handshake
    logic              ex_valid;
    logic              ex_ready;
    logic [5:0]        ex_funct;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [ADDR_W-1:0] ex_rd;
    logic              ex_we;
    logic              ex_ilegal;

    modport slave (
        input  inst_valid, inst, wb_en, wb_addr, wb_data, dr1, dr2, ex_ready,
        output inst_ready, ra1, ra2, reg_write, dir, di,
               ex_valid, ex_funct, ex_a, ex_b, ex_rd, ex_we, ex_ilegal
    );

    modport master (
        output inst_valid, inst, wb_en, wb_addr, wb_data, dr1, dr2, ex_ready,
        input  inst_ready, ra1, ra2, reg_write, dir, di,
               ex_valid, ex_funct, ex_a, ex_b, ex_rd, ex_we, ex_ilegal
    );
endinterface

// File: rtl/etapa_decodificacion.sv
// Decode / operand-fetch stage: D holds the instruction, E holds fetched operands.
// Operands are sampled on the D->E transfer edge with same-cycle writeback bypass.

// One operand lane: zero register, then writeback bypass, then register file data.
module etapa_decodificacion_opsel #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] src,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] dir,
    input  logic [DATA_W-1:0] di,
    output logic [DATA_W-1:0] val
);
    always_comb begin
        val = rf_data;
        if (src == '0)
            val = '0;
        else if (reg_write && (dir == src))
            val = di;
    end
endmodule

module etapa_decodificacion #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    etapa_decodificacion_if.slave  bus
);
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic [5:0]        op;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] rd;
        logic [4:0]        sh;
        logic [5:0]        funct;
    } rinst_t;

    typedef struct packed {
        logic [5:0]        funct;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic              ilegal;
    } ex_t;

    // state bits are {d_valid, ex_valid}
    typedef enum logic [1:0] {
        VACIO  = 2'b00,
        SOLO_E = 2'b01,
        SOLO_D = 2'b10,
        LLENO  = 2'b11
    } estado_t;

    estado_t state, state_nx;
    rinst_t  d_q;
    ex_t     e_q, e_nx;

    logic d_valid, ex_valid;
    logic e_adv, inst_ready, d_load;
    logic reg_write;

    logic [NUM_OPS-1:0][ADDR_W-1:0] op_src;
    logic [NUM_OPS-1:0][DATA_W-1:0] op_rf;
    logic [NUM_OPS-1:0][DATA_W-1:0] op_val;

    assign d_valid    = state[1];
    assign ex_valid   = state[0];
    assign e_adv      = d_valid & (~ex_valid | bus.ex_ready);
    assign inst_ready = ~d_valid | e_adv;
    assign d_load     = bus.inst_valid & inst_ready;

    // Writeback forwarding; r0 is hard-wired so its writes are squashed here.
    assign reg_write     = bus.wb_en & (bus.wb_addr != '0);
    assign bus.reg_write = reg_write;
    assign bus.dir       = bus.wb_addr;
    assign bus.di        = bus.wb_data;

    assign bus.ra1 = d_q.rs;
    assign bus.ra2 = d_q.rt;

    assign op_src = {d_q.rt, d_q.rs};
    assign op_rf  = {bus.dr2, bus.dr1};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        etapa_decodificacion_opsel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_opsel (
            .src       (op_src[g]),
            .rf_data   (op_rf[g]),
            .reg_write (reg_write),
            .dir       (bus.wb_addr),
            .di        (bus.wb_data),
            .val       (op_val[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= VACIO;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            VACIO:  if (d_load) state_nx = SOLO_D;
            SOLO_D: state_nx = d_load ? LLENO : SOLO_E;
            SOLO_E: begin
                if (d_load)
                    state_nx = bus.ex_ready ? SOLO_D : LLENO;
                else
                    state_nx = bus.ex_ready ? VACIO : SOLO_E;
            end
            LLENO:  if (bus.ex_ready) state_nx = d_load ? LLENO : SOLO_E;
            default: state_nx = VACIO;
        endcase
    end

    always_comb begin
        e_nx        = e_q;
        e_nx.funct  = d_q.funct;
        e_nx.a      = op_val[0];
        e_nx.b      = op_val[1];
        e_nx.rd     = d_q.rd;
        e_nx.ilegal = (d_q.op != 6'b000000);
        e_nx.we     = (d_q.op == 6'b000000) && (d_q.rd != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            d_q <= '0;
        else if (d_load)
            d_q <= rinst_t'(bus.inst);
    end

    // E only changes on a transfer, so a stalled execute sees stable operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            e_q <= '0;
        else if (e_adv)
            e_q <= e_nx;
    end

    assign bus.inst_ready = inst_ready;
    assign bus.ex_valid   = ex_valid;
    assign bus.ex_funct   = e_q.funct;
    assign bus.ex_a       = e_q.a;
    assign bus.ex_b       = e_q.b;
    assign bus.ex_rd      = e_q.rd;
    assign bus.ex_we      = e_q.we;
    assign bus.ex_ilegal  = e_q.ilegal;
endmodule
